// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bus for the MIPS instruction encoder/loader.
// The master drives requests and the slave (the encoder) drives the IM write port.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [4:0]        req_rs;
    logic [4:0]        req_rt;
    logic [4:0]        req_rd;
    logic [4:0]        req_shamt;
    logic [15:0]       req_imm;
    logic [25:0]       req_target;
    logic              req_last;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output req_valid, req_op, req_rs, req_rt, req_rd, req_shamt,
               req_imm, req_target, req_last,
        input  req_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, req_rd, req_shamt,
               req_imm, req_target, req_last,
        output req_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs one symbolic MIPS operation per handshake into a 32-bit word and writes
// it to consecutive IM addresses.  state | meaning: IDLE accept | WRITE strobe IM | DONE sticky end.
module instr_encoder_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    instr_encoder_loader_if.slave  bus,
    output logic [ADDR_W:0]        o_count,
    output logic                   o_done,
    output logic                   o_err_op,
    output logic                   o_err_full
);
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] L_LAST = '1;

    state_t            r_state;
    logic              r_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_ptr;
    logic [31:0]       r_wdata;
    logic              r_last;
    logic [ADDR_W:0]   r_count;
    logic              r_done;
    logic              r_err_op;
    logic              r_err_full;

    logic [31:0]       w_enc;
    logic              w_legal;

    // Only the fields an op actually uses are concatenated; everything else is zero.
    always_comb begin
        w_enc   = '0;
        w_legal = 1'b1;
        case (bus.req_op)
            4'd0:    w_enc = 32'h0000_0000;
            4'd1:    w_enc = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h21};
            4'd2:    w_enc = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h23};
            4'd3:    w_enc = {6'h00, 5'd0, bus.req_rt, bus.req_rd, bus.req_shamt, 6'h00};
            4'd4:    w_enc = {6'h00, bus.req_rs, 15'd0, 6'h08};
            4'd5:    w_enc = {6'h0D, bus.req_rs, bus.req_rt, bus.req_imm};
            4'd6:    w_enc = {6'h23, bus.req_rs, bus.req_rt, bus.req_imm};
            4'd7:    w_enc = {6'h2B, bus.req_rs, bus.req_rt, bus.req_imm};
            4'd8:    w_enc = {6'h04, bus.req_rs, bus.req_rt, bus.req_imm};
            4'd9:    w_enc = {6'h0F, 5'd0, bus.req_rt, bus.req_imm};
            4'd10:   w_enc = {6'h03, bus.req_target};
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_we       <= 1'b0;
            r_ptr      <= L_BASE;
            r_wdata    <= '0;
            r_last     <= 1'b0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_err_op   <= 1'b0;
            r_err_full <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_ready) begin
                        if (w_legal) begin
                            r_wdata <= w_enc;
                            r_last  <= bus.req_last;
                            r_we    <= 1'b1;
                            r_ready <= 1'b0;
                            r_state <= S_WRITE;
                        end else begin
                            r_err_op <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_we    <= 1'b0;
                    r_count <= r_count + (ADDR_W+1)'(1);
                    if (r_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                        if (r_ptr != L_LAST) r_ptr <= r_ptr + ADDR_W'(1);
                    end else if (r_ptr == L_LAST) begin
                        // Top of IM reached: stop rather than wrap onto earlier words.
                        r_done     <= 1'b1;
                        r_err_full <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_ptr   <= r_ptr + ADDR_W'(1);
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    r_we    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.im_we     = r_we;
    assign bus.im_addr   = r_ptr;
    assign bus.im_wdata  = r_wdata;
    assign o_count       = r_count;
    assign o_done        = r_done;
    assign o_err_op      = r_err_op;
    assign o_err_full    = r_err_full;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a 10-bit-address instance for encoding and
// sequencing, and a 2-bit-address instance for the capacity limit.
module tb_instr_encoder_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    logic        t_valid = 1'b0;
    logic [3:0]  t_op = '0;
    logic [4:0]  t_rs = '0, t_rt = '0, t_rd = '0, t_sh = '0;
    logic [15:0] t_imm = '0;
    logic [25:0] t_tgt = '0;
    logic        t_last = 1'b0;

    instr_encoder_loader_if #(.ADDR_W(10)) bb ();
    instr_encoder_loader_if #(.ADDR_W(2))  bs ();

    assign bb.req_valid = t_valid & ~sel;
    assign bs.req_valid = t_valid & sel;
    assign bb.req_op = t_op;      assign bs.req_op = t_op;
    assign bb.req_rs = t_rs;      assign bs.req_rs = t_rs;
    assign bb.req_rt = t_rt;      assign bs.req_rt = t_rt;
    assign bb.req_rd = t_rd;      assign bs.req_rd = t_rd;
    assign bb.req_shamt = t_sh;   assign bs.req_shamt = t_sh;
    assign bb.req_imm = t_imm;    assign bs.req_imm = t_imm;
    assign bb.req_target = t_tgt; assign bs.req_target = t_tgt;
    assign bb.req_last = t_last;  assign bs.req_last = t_last;

    logic [10:0] b_count;
    logic        b_done, b_err_op, b_err_full;
    logic [2:0]  s_count;
    logic        s_done, s_err_op, s_err_full;

    instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0)) u_big (
        .i_clk(clk), .i_reset(reset), .bus(bb),
        .o_count(b_count), .o_done(b_done), .o_err_op(b_err_op), .o_err_full(b_err_full)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
        .i_clk(clk), .i_reset(reset), .bus(bs),
        .o_count(s_count), .o_done(s_done), .o_err_op(s_err_op), .o_err_full(s_err_full)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];

    wire w_ready = sel ? bs.req_ready : bb.req_ready;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sel ? bs.im_we : bb.im_we) begin
            wa.push_back(sel ? 32'(bs.im_addr) : 32'(bb.im_addr));
            wd.push_back(sel ? bs.im_wdata : bb.im_wdata);
            wc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        t_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        wa.delete(); wd.delete(); wc.delete();
    endtask

    // Handshake attempt with a bounded wait; valid is left high for back-to-back use.
    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last, output bit acc);
        int n;
        acc = 1'b0;
        n = 0;
        @(negedge clk);
        t_op = op; t_rs = rs; t_rt = rt; t_rd = rd; t_sh = sh;
        t_imm = imm; t_tgt = tgt; t_last = last; t_valid = 1'b1;
        while (!acc && n < 12) begin
            if (w_ready) begin
                last_acc = cyc + 1;
                @(posedge clk);
                acc = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        t_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        n_cmp++; if (bb.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", bb.req_ready); end
        n_cmp++; if (bb.im_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b exp=0", bb.im_we); end
        n_cmp++; if (bb.im_addr !== 10'd0) begin n_bad++; $display("FAIL reset_addr got=%0d exp=0", bb.im_addr); end
        n_cmp++; if (bb.im_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata got=%h exp=0", bb.im_wdata); end
        n_cmp++; if (b_count !== 11'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", b_count); end
        n_cmp++; if ({b_done, b_err_op, b_err_full} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=000", {b_done, b_err_op, b_err_full});
        end
        n_cmp++; if (s_count !== 3'd0 || s_done !== 1'b0 || bs.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_small got count=%0d done=%b ready=%b exp 0 0 1", s_count, s_done, bs.req_ready);
        end
    endtask

    task automatic test_addu();
        bit acc;
        sel = 1'b0;
        do_reset();
        send(4'd1, 5'd1, 5'd2, 5'd3, 5'd7, 16'hABCD, 26'h3FFFFFF, 1'b0, acc);
        settle();
        n_cmp++; if (wa.size() !== 1) begin n_bad++; $display("FAIL addu_nwrites got=%0d exp=1", wa.size()); end
        else begin
            n_cmp++; if (wa[0] !== 32'd0) begin n_bad++; $display("FAIL addu_addr got=%0d exp=0", wa[0]); end
            n_cmp++; if (wd[0] !== 32'h00221821) begin n_bad++; $display("FAIL addu_data got=%h exp=00221821", wd[0]); end
            n_cmp++; if (wc[0] !== last_acc) begin n_bad++; $display("FAIL addu_latency got=%0d exp=%0d", wc[0], last_acc); end
        end
        n_cmp++; if (b_count !== 11'd1) begin n_bad++; $display("FAIL addu_count got=%0d exp=1", b_count); end
        n_cmp++; if (bb.req_ready !== 1'b1 || b_done !== 1'b0) begin
            n_bad++; $display("FAIL addu_idle got ready=%b done=%b exp 1 0", bb.req_ready, b_done);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h34011234; exp_d[1] = 32'h3C08FFFF;
        exp_d[2] = 32'hAC050004; exp_d[3] = 32'h1022FFFF;
        sel = 1'b0;
        do_reset();
        send(4'd5, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'd0, 1'b0, acc);
        send(4'd9, 5'd9, 5'd8, 5'd6, 5'd4, 16'hFFFF, 26'h155, 1'b0, acc);
        send(4'd7, 5'd0, 5'd5, 5'd0, 5'd0, 16'h0004, 26'd0, 1'b0, acc);
        send(4'd8, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1'b0, acc);
        settle();
        n_cmp++; if (wa.size() !== 4) begin n_bad++; $display("FAIL b2b_nwrites got=%0d exp=4", wa.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (wa[i] !== 32'(i) || wd[i] !== exp_d[i]) begin
                    n_bad++; $display("FAIL b2b_word%0d got addr=%0d data=%h exp addr=%0d data=%h", i, wa[i], wd[i], i, exp_d[i]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (wc[i+1] - wc[i] !== 2) begin
                    n_bad++; $display("FAIL b2b_spacing%0d got=%0d exp=2", i, wc[i+1] - wc[i]);
                end
            end
        end
        n_cmp++; if (b_count !== 11'd4) begin n_bad++; $display("FAIL b2b_count got=%0d exp=4", b_count); end
    endtask

    task automatic test_jump_last();
        bit acc;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h000220C0; exp_d[1] = 32'h03E00008; exp_d[2] = 32'h0C000C03;
        sel = 1'b0;
        do_reset();
        send(4'd3, 5'd17, 5'd2, 5'd4, 5'd3, 16'hFFFF, 26'd0, 1'b0, acc);
        send(4'd4, 5'd31, 5'd9, 5'd9, 5'd9, 16'hFFFF, 26'd0, 1'b0, acc);
        send(4'd10, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000C03, 1'b1, acc);
        settle();
        n_cmp++; if (wa.size() !== 3) begin n_bad++; $display("FAIL jump_nwrites got=%0d exp=3", wa.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (wa[i] !== 32'(i) || wd[i] !== exp_d[i]) begin
                    n_bad++; $display("FAIL jump_word%0d got addr=%0d data=%h exp addr=%0d data=%h", i, wa[i], wd[i], i, exp_d[i]);
                end
            end
        end
        n_cmp++; if (b_done !== 1'b1 || bb.req_ready !== 1'b0 || b_err_full !== 1'b0) begin
            n_bad++; $display("FAIL jump_done got done=%b ready=%b err_full=%b exp 1 0 0", b_done, bb.req_ready, b_err_full);
        end
        n_cmp++; if (b_count !== 11'd3) begin n_bad++; $display("FAIL jump_count got=%0d exp=3", b_count); end
        send(4'd1, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0, 1'b0, acc);
        settle();
        n_cmp++; if (acc !== 1'b0 || wa.size() !== 3) begin
            n_bad++; $display("FAIL done_ignores got acc=%b nwrites=%0d exp 0 3", acc, wa.size());
        end
    endtask

    task automatic test_illegal_op();
        bit acc;
        sel = 1'b0;
        do_reset();
        send(4'd12, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5555, 26'h1, 1'b0, acc);
        settle();
        n_cmp++; if (wa.size() !== 0) begin n_bad++; $display("FAIL illegal_nowrite got=%0d exp=0", wa.size()); end
        n_cmp++; if (b_err_op !== 1'b1 || bb.req_ready !== 1'b1 || b_done !== 1'b0) begin
            n_bad++; $display("FAIL illegal_flags got err_op=%b ready=%b done=%b exp 1 1 0", b_err_op, bb.req_ready, b_done);
        end
        n_cmp++; if (b_count !== 11'd0) begin n_bad++; $display("FAIL illegal_count got=%0d exp=0", b_count); end
        send(4'd6, 5'd29, 5'd4, 5'd7, 5'd7, 16'h0010, 26'd0, 1'b0, acc);
        settle();
        n_cmp++; if (wa.size() !== 1) begin n_bad++; $display("FAIL illegal_next_nwrites got=%0d exp=1", wa.size()); end
        else begin
            n_cmp++; if (wa[0] !== 32'd0 || wd[0] !== 32'h8FA40010) begin
                n_bad++; $display("FAIL illegal_next_word got addr=%0d data=%h exp addr=0 data=8fa40010", wa[0], wd[0]);
            end
        end
        n_cmp++; if (b_err_op !== 1'b1) begin n_bad++; $display("FAIL illegal_sticky got=%b exp=1", b_err_op); end
    endtask

    task automatic test_full();
        bit acc;
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h00000021; exp_d[1] = 32'h00200021;
        exp_d[2] = 32'h00400021; exp_d[3] = 32'h00600021;
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(4'd1, 5'(i), 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0, acc);
            n_cmp++; if (acc !== (i < 4)) begin
                n_bad++; $display("FAIL full_accept%0d got=%b exp=%b", i, acc, (i < 4));
            end
        end
        settle();
        n_cmp++; if (wa.size() !== 4) begin n_bad++; $display("FAIL full_nwrites got=%0d exp=4", wa.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (wa[i] !== 32'(i) || wd[i] !== exp_d[i]) begin
                    n_bad++; $display("FAIL full_word%0d got addr=%0d data=%h exp addr=%0d data=%h", i, wa[i], wd[i], i, exp_d[i]);
                end
            end
        end
        n_cmp++; if (s_done !== 1'b1 || s_err_full !== 1'b1 || bs.req_ready !== 1'b0) begin
            n_bad++; $display("FAIL full_flags got done=%b err_full=%b ready=%b exp 1 1 0", s_done, s_err_full, bs.req_ready);
        end
        n_cmp++; if (s_count !== 3'd4) begin n_bad++; $display("FAIL full_count got=%0d exp=4", s_count); end
        sel = 1'b0;
    endtask

    task automatic test_reset_in_write();
        bit acc;
        sel = 1'b0;
        do_reset();
        send(4'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0, acc);
        send(4'd2, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 26'd0, 1'b0, acc);
        #1;
        reset = 1'b1;
        t_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++; if (bb.im_we !== 1'b0) begin n_bad++; $display("FAIL rstwr_we got=%b exp=0", bb.im_we); end
        n_cmp++; if (b_count !== 11'd0 || bb.im_addr !== 10'd0) begin
            n_bad++; $display("FAIL rstwr_state got count=%0d addr=%0d exp 0 0", b_count, bb.im_addr);
        end
        @(negedge clk);
        wa.delete(); wd.delete(); wc.delete();
        send(4'd0, 5'd7, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h1, 1'b0, acc);
        settle();
        n_cmp++; if (wa.size() !== 1) begin n_bad++; $display("FAIL rstwr_nwrites got=%0d exp=1", wa.size()); end
        else begin
            n_cmp++; if (wa[0] !== 32'd0 || wd[0] !== 32'h0) begin
                n_bad++; $display("FAIL rstwr_word got addr=%0d data=%h exp addr=0 data=0", wa[0], wd[0]);
            end
        end
        n_cmp++; if (b_count !== 11'd1) begin n_bad++; $display("FAIL rstwr_count got=%0d exp=1", b_count); end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_back_to_back();
        test_jump_last();
        test_illegal_op();
        test_full();
        test_reset_in_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
